torpedo_scheduler: RTL and testbench



---
 rtl/torpedo_pkg.sv | 24 ++
 rtl/torpedo_scheduler_rr_pick.sv | 31 +++
 rtl/torpedo_scheduler.sv | 130 +++++++++++++
 tb/tb_torpedo_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/torpedo_pkg.sv
// Shared types and defaults for the torpedo launch scheduler and the game top.
package torpedo_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    COOLDOWN = 1'b1
  } sched_state_t;

  localparam int DEF_T_NUM           = 4;
  localparam int DEF_COOLDOWN_FRAMES = 6;
  localparam int DEF_LIFE_FRAMES     = 90;

  localparam int PTR_W  = 3;
  localparam int CD_W   = 6;
  localparam int LIFE_W = 8;

  typedef struct packed {
    sched_state_t      state;
    logic              pending;
    logic [PTR_W-1:0]  rr_ptr;
    logic [CD_W-1:0]   cd_cnt;
  } sched_dbg_t;

endpackage

// File: rtl/torpedo_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick
  import torpedo_pkg::*;
#(
  parameter int T_NUM = DEF_T_NUM
) (
  input  logic [T_NUM-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [T_NUM-1:0] grant,
  output logic             valid
);

  // First pass covers ptr..T_NUM-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < T_NUM; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int i = 0; i < T_NUM; i++) begin
      if (!valid && req[i]) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/torpedo_scheduler.sv
// Turns fire-button presses into one-hot launch pulses for free torpedo slots,
// with a frame cooldown, a one-deep pending request and per-slot flight tracking.
module torpedo_scheduler
  import torpedo_pkg::*;
#(
  parameter int T_NUM           = DEF_T_NUM,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int LIFE_FRAMES     = DEF_LIFE_FRAMES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vsync_pulse,
  input  logic                         enable,
  input  logic                         fire_btn,
  input  logic [T_NUM-1:0]             slot_done,
  output logic [T_NUM-1:0]             fire,
  output logic [T_NUM-1:0]             busy,
  output logic [$clog2(T_NUM+1)-1:0]   active_cnt,
  output logic                         ready,
  output sched_dbg_t                   dbg
);

  localparam int CW = $clog2(T_NUM+1);

  sched_state_t      state;
  logic              pending;
  logic [PTR_W-1:0]  rr_ptr;
  logic [CD_W-1:0]   cd_cnt;
  logic              btn_q, btn_prev;
  logic [LIFE_W-1:0] life_cnt [T_NUM];

  logic              press, want, cd_last, launch_window, launch, idle_n, pick_valid;
  logic [T_NUM-1:0]  grant, busy_n;
  logic [LIFE_W-1:0] life_n [T_NUM];
  logic [PTR_W-1:0]  ptr_n;
  logic [CW-1:0]     cnt_n;

  rr_pick #(.T_NUM(T_NUM)) u_pick (
    .req   (~busy),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (pick_valid)
  );

  // The frame that ends the cooldown may launch directly, so a buffered
  // request fires in the cycle right after the final vsync.
  assign press         = btn_q & ~btn_prev;
  assign want          = press | pending;
  assign cd_last       = vsync_pulse && (cd_cnt <= CD_W'(1));
  assign launch_window = (state == IDLE) || ((state == COOLDOWN) && cd_last);
  assign launch        = launch_window && want && enable && pick_valid;
  assign idle_n        = launch ? (COOLDOWN_FRAMES == 0) : launch_window;

  always_comb begin
    ptr_n = rr_ptr;
    for (int i = 0; i < T_NUM; i++) begin
      if (grant[i]) ptr_n = (i == T_NUM-1) ? '0 : PTR_W'(i+1);
    end
  end

  // A fresh launch wins over decrement; done and expiry collapse into one clear.
  always_comb begin
    busy_n = busy;
    cnt_n  = '0;
    for (int i = 0; i < T_NUM; i++) begin
      life_n[i] = life_cnt[i];
      if (launch && grant[i]) begin
        busy_n[i] = 1'b1;
        life_n[i] = LIFE_W'(LIFE_FRAMES);
      end else if (busy[i]) begin
        if (vsync_pulse && (life_cnt[i] != '0)) life_n[i] = life_cnt[i] - LIFE_W'(1);
        if (slot_done[i] || (vsync_pulse && (life_cnt[i] == LIFE_W'(1)))) busy_n[i] = 1'b0;
      end
      cnt_n = cnt_n + CW'(busy_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      rr_ptr     <= '0;
      cd_cnt     <= '0;
      btn_q      <= 1'b1;
      btn_prev   <= 1'b1;
      fire       <= '0;
      busy       <= '0;
      active_cnt <= '0;
      ready      <= 1'b1;
      for (int i = 0; i < T_NUM; i++) life_cnt[i] <= '0;
    end else begin
      btn_q      <= fire_btn;
      btn_prev   <= btn_q;
      fire       <= launch ? grant : '0;
      busy       <= busy_n;
      active_cnt <= cnt_n;
      ready      <= idle_n & (|(~busy_n));
      for (int i = 0; i < T_NUM; i++) life_cnt[i] <= life_n[i];

      if (launch) begin
        rr_ptr  <= ptr_n;
        cd_cnt  <= CD_W'(COOLDOWN_FRAMES);
        pending <= 1'b0;
        state   <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
      end else begin
        case (state)
          IDLE: pending <= 1'b0;
          COOLDOWN: begin
            if (vsync_pulse && (cd_cnt != '0)) cd_cnt <= cd_cnt - CD_W'(1);
            if (cd_last) begin
              state   <= IDLE;
              pending <= 1'b0;
            end else begin
              pending <= enable & want;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    dbg.state   = state;
    dbg.pending = pending;
    dbg.rr_ptr  = rr_ptr;
    dbg.cd_cnt  = cd_cnt;
  end

endmodule

// File: tb/tb_torpedo_scheduler.sv
// Directed bench for torpedo_scheduler: a default 4-slot instance plus a
// 2-slot, no-cooldown, 3-frame-lifetime instance for lifetime edge cases.
module tb_torpedo_scheduler;
  import torpedo_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync_pulse = 1'b0;
  logic       enable = 1'b1;
  logic       fire_btn = 1'b1;
  logic [3:0] slot_done = '0;
  logic [3:0] fire, busy;
  logic [2:0] active_cnt;
  logic       ready;
  sched_dbg_t dbg;

  logic       fire_btn2 = 1'b0;
  logic [1:0] slot_done2 = '0;
  logic [1:0] fire2, busy2;
  logic [1:0] active_cnt2;
  logic       ready2;
  sched_dbg_t dbg2;

  int checks = 0;
  int errors = 0;
  int fire_cnt = 0;
  int fire_cnt2 = 0;

  torpedo_scheduler #(.T_NUM(4), .COOLDOWN_FRAMES(6), .LIFE_FRAMES(90)) u_dut (
    .clk(clk), .reset(reset), .vsync_pulse(vsync_pulse), .enable(enable),
    .fire_btn(fire_btn), .slot_done(slot_done), .fire(fire), .busy(busy),
    .active_cnt(active_cnt), .ready(ready), .dbg(dbg)
  );

  torpedo_scheduler #(.T_NUM(2), .COOLDOWN_FRAMES(0), .LIFE_FRAMES(3)) u_dut2 (
    .clk(clk), .reset(reset), .vsync_pulse(vsync_pulse), .enable(enable),
    .fire_btn(fire_btn2), .slot_done(slot_done2), .fire(fire2), .busy(busy2),
    .active_cnt(active_cnt2), .ready(ready2), .dbg(dbg2)
  );

  // clock / reset
  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (fire != '0) fire_cnt++;
    if (fire2 != '0) fire_cnt2++;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vsync();
    vsync_pulse = 1'b1;
    tick(1);
    vsync_pulse = 1'b0;
  endtask

  task automatic press();
    fire_btn = 1'b1;
    tick(1);
    fire_btn = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] m);
    slot_done = m;
    tick(1);
    slot_done = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with button held
    tick(3);
    check("rst_fire", 32'(fire), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_active", 32'(active_cnt), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    tick(10);
    check("held_no_fire", 32'(fire_cnt), 32'd0);
    check("held_ready", 32'(ready), 32'd1);
    check("held_busy", 32'(busy), 32'h0);
    check("held_state", 32'(dbg.state), 32'(IDLE));
    check("held_ptr", 32'(dbg.rr_ptr), 32'd0);
    fire_btn = 1'b0;
    tick(2);

    // four launches round-robin with full cooldown between
    press();
    check("lat_pre", 32'(fire), 32'h0);
    tick(1);
    check("l1_fire", 32'(fire), 32'h1);
    check("l1_busy", 32'(busy), 32'h1);
    check("l1_active", 32'(active_cnt), 32'd1);
    check("l1_ready", 32'(ready), 32'd0);
    check("l1_ptr", 32'(dbg.rr_ptr), 32'd1);
    tick(1);
    check("l1_pulse_one", 32'(fire), 32'h0);
    repeat (5) vsync();
    check("cd5_ready", 32'(ready), 32'd0);
    vsync();
    check("cd6_ready", 32'(ready), 32'd1);
    check("cd6_state", 32'(dbg.state), 32'(IDLE));

    press(); tick(1);
    check("l2_fire", 32'(fire), 32'h2);
    repeat (6) vsync();
    press(); tick(1);
    check("l3_fire", 32'(fire), 32'h4);
    repeat (6) vsync();
    press(); tick(1);
    check("l4_fire", 32'(fire), 32'h8);
    check("l4_active", 32'(active_cnt), 32'd4);
    repeat (6) vsync();
    check("full_ready", 32'(ready), 32'd0);
    check("full_state", 32'(dbg.state), 32'(IDLE));
    press(); tick(2);
    check("drop_count", 32'(fire_cnt), 32'd4);
    check("drop_pending", 32'(dbg.pending), 32'd0);

    // slot_done frees slot 1; rr_ptr is 0 and slot 0 busy, so slot 1 is picked
    pulse_done(4'b0010);
    check("done1_busy", 32'(busy), 32'hD);
    check("done1_active", 32'(active_cnt), 32'd3);
    check("done1_ready", 32'(ready), 32'd1);
    press(); tick(1);
    check("relaunch_fire", 32'(fire), 32'h2);
    check("relaunch_ptr", 32'(dbg.rr_ptr), 32'd2);

    // pending request buffered two frames into cooldown
    pulse_done(4'b1000);
    repeat (2) vsync();
    press(); tick(1);
    check("pend_set", 32'(dbg.pending), 32'd1);
    press(); tick(1);
    repeat (3) vsync();
    check("pend_wait", 32'(fire_cnt), 32'd5);
    vsync();
    check("pend_fire", 32'(fire), 32'h8);
    repeat (6) vsync();
    tick(2);
    check("pend_once", 32'(fire_cnt), 32'd6);
    check("pend_idle", 32'(dbg.state), 32'(IDLE));

    // slot_done on an idle slot is ignored
    pulse_done(4'b0100);
    check("done2_busy", 32'(busy), 32'hB);
    pulse_done(4'b0100);
    check("done2_ignored", 32'(busy), 32'hB);
    check("done2_active", 32'(active_cnt), 32'd3);

    // enable low blocks the launch and leaves nothing pending
    enable = 1'b0;
    press(); tick(2);
    check("dis_no_fire", 32'(fire_cnt), 32'd6);
    check("dis_pending", 32'(dbg.pending), 32'd0);
    enable = 1'b1;
    tick(2);
    check("dis_no_late", 32'(fire_cnt), 32'd6);

    // reset mid-cooldown with two slots busy
    pulse_done(4'b1001);
    press(); tick(1);
    check("pre_rst_fire", 32'(fire), 32'h1);
    check("pre_rst_busy", 32'(busy), 32'h3);
    repeat (2) vsync();
    fire_btn = 1'b1;
    reset = 1'b1;
    tick(1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(3);
    check("post_rst_fire", 32'(fire_cnt), 32'd7);
    check("post_rst_state", 32'(dbg.state), 32'(IDLE));
    check("post_rst_ptr", 32'(dbg.rr_ptr), 32'd0);
    check("post_rst_cd", 32'(dbg.cd_cnt), 32'd0);
    check("post_rst_ready", 32'(ready), 32'd1);
    fire_btn = 1'b0;
    tick(2);
    press(); tick(1);
    check("post_rst_launch", 32'(fire), 32'h1);

    // lifetime 3 frames, vsync coincident with the launch edge
    fire_btn2 = 1'b1;
    tick(1);
    fire_btn2 = 1'b0;
    vsync_pulse = 1'b1;
    tick(1);
    vsync_pulse = 1'b0;
    check("life_fire", 32'(fire2), 32'h1);
    check("life_busy0", 32'(busy2), 32'h1);
    vsync();
    vsync();
    check("life_busy2", 32'(busy2), 32'h1);
    vsync();
    check("life_expired", 32'(busy2), 32'h0);
    check("life_active", 32'(active_cnt2), 32'd0);
    fire_btn2 = 1'b1;
    tick(1);
    fire_btn2 = 1'b0;
    tick(1);
    check("nocd_fire", 32'(fire2), 32'h2);
    check("nocd_ready", 32'(ready2), 32'd1);
    tick(2);
    check("life_count2", 32'(fire_cnt2), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
